paddle_ctrl: RTL and testbench
==============================

PADDLE_CTRL -- requirements
Module: paddle_ctrl

Interface
REQ-001 SHALL have parameter PX, default 600, paddle centre x (fixed).
REQ-002 SHALL have parameter PY, default 240, paddle initial/recentre y.
REQ-003 SHALL have parameter P_HW, default 5, paddle half width.
REQ-004 SHALL have parameter P_HH, default 40, paddle half height.
REQ-005 SHALL have parameter D_HEIGHT, default 480, display height.
REQ-006 SHALL have parameter SLOW_SPD, default 2, pixels/frame in SLOW.
REQ-007 SHALL have parameter FAST_SPD, default 6, pixels/frame in FAST.
REQ-008 SHALL have parameter ACCEL_FRAMES, default 16, SLOW frames before FAST.
REQ-009 SHALL have port i_clk  in  1  base clock, single clock domain.
REQ-010 SHALL have port i_rst  in  1  asynchronous, active-high reset.
REQ-011 SHALL have port i_ani_stb  in  1  one-cycle animation strobe, one per frame.
REQ-012 SHALL have port i_animate  in  1  animation enable qualifier.
REQ-013 SHALL have port i_enable  in  1  play enable (game toggle).
REQ-014 SHALL have port i_mode  in  2  game mode; 0 = not playing.
REQ-015 SHALL have port i_btn_up  in  1  raw up button, asynchronous.
REQ-016 SHALL have port i_btn_dn  in  1  raw down button, asynchronous.
REQ-017 SHALL have ports o_x1, o_x2, o_y1, o_y2  out  12 each  paddle left, right, top, bottom edges.
REQ-018 SHALL have port o_com  out  2  motion on last frame: bit0 moved up, bit1 moved down.
REQ-019 SHALL have port o_fast  out  1  high while state is FAST.

Function
REQ-020 SHALL pass each button through a 2-flop synchronizer; only synchronized values are used.
REQ-021 SHALL define frame tick = i_ani_stb & i_animate & i_enable; state, hold counter, y and o_com change only on a tick, except REQ-029.
REQ-022 SHALL decode request: up only -> UP, down only -> DN, both or neither -> NONE.
REQ-023 SHALL implement states IDLE, SLOW, FAST with a hold counter sized for ACCEL_FRAMES-1.
REQ-024 SHALL on tick with NONE: next state IDLE, hold counter 0, no move, o_com 00.
REQ-025 SHALL on tick from IDLE with UP/DN: next SLOW, hold counter 0, move SLOW_SPD.
REQ-026 SHALL on tick in SLOW with same direction: if hold counter = ACCEL_FRAMES-1 go FAST and move FAST_SPD, else increment counter and move SLOW_SPD.
REQ-027 SHALL on tick in FAST with same direction: stay FAST, move FAST_SPD.
REQ-028 SHALL on tick in SLOW/FAST with reversed direction: go SLOW, counter 0, move SLOW_SPD in new direction.
REQ-029 SHALL, when i_mode = 0, on every clock (priority over tick) set y = PY, state IDLE, counter 0, o_com 00.
REQ-030 SHALL clamp y to [P_HH, D_HEIGHT-P_HH]: up move sets y = max(y-spd, P_HH), down sets y = min(y+spd, D_HEIGHT-P_HH); no underflow/overflow of the 12-bit y.
REQ-031 SHALL set o_com bit0/bit1 on a tick only if y actually decreased/increased; clamped-still gives 00; o_com holds between ticks.
REQ-032 SHALL drive o_x1 = PX-P_HW, o_x2 = PX+P_HW constant; o_y1 = y-P_HH, o_y2 = y+P_HH combinationally from registered y.
REQ-033 SHALL have latency: button edge -> synchronized after 2 clocks; y changes on first tick thereafter.

Reset
REQ-034 SHALL on i_rst, asynchronously: y = PY, state IDLE, counter 0, o_com 00, o_fast 0, synchronizer flops 0.
REQ-035 SHALL abandon any motion on reset mid-operation; first post-reset tick behaves as from IDLE.

Verification
REQ-036 Reset asserted -> o_x1=595, o_x2=605, o_y1=200, o_y2=280, o_com=00, o_fast=0.
REQ-037 Hold up, 16 ticks -> y=208 (o_y1=168), o_com=01, o_fast=0; 17th tick -> y=202, o_fast=1.
REQ-038 Hold up until clamp -> o_y1=0, o_y2=80; next tick o_com=00, y unchanged; hold down, same at bottom: o_y2=480.
REQ-039 Both buttons from y=240 for 5 ticks -> y=240, state IDLE, o_com=00; i_ani_stb with i_animate=0 -> no change.
REQ-040 In FAST moving up, switch to down -> next tick y +2, o_fast=0, o_com=10.
REQ-041 i_mode driven 0 mid-motion at y=150 -> y=240 next clock, o_com=00; i_rst pulse mid-FAST -> same values asynchronously.

Source files
------------

// File: rtl/paddle_ctrl.sv
// Paddle position controller: synchronizes raw up/down buttons and moves the
// paddle once per animation frame, accelerating from SLOW to FAST on a long hold.
module paddle_ctrl #(
    parameter int PX           = 600,
    parameter int PY           = 240,
    parameter int P_HW         = 5,
    parameter int P_HH         = 40,
    parameter int D_HEIGHT     = 480,
    parameter int SLOW_SPD     = 2,
    parameter int FAST_SPD     = 6,
    parameter int ACCEL_FRAMES = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ani_stb,
    input  logic        i_animate,
    input  logic        i_enable,
    input  logic [1:0]  i_mode,
    input  logic        i_btn_up,
    input  logic        i_btn_dn,
    output logic [11:0] o_x1,
    output logic [11:0] o_x2,
    output logic [11:0] o_y1,
    output logic [11:0] o_y2,
    output logic [1:0]  o_com,
    output logic        o_fast
);

    localparam int CNT_W = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;

    localparam logic [11:0]      Y_INIT   = 12'(PY);
    localparam logic [11:0]      Y_MIN    = 12'(P_HH);
    localparam logic [11:0]      Y_MAX    = 12'(D_HEIGHT - P_HH);
    localparam logic [11:0]      HALF_H   = 12'(P_HH);
    localparam logic [11:0]      X_LEFT   = 12'(PX - P_HW);
    localparam logic [11:0]      X_RIGHT  = 12'(PX + P_HW);
    localparam logic [11:0]      SPD_SLOW = 12'(SLOW_SPD);
    localparam logic [11:0]      SPD_FAST = 12'(FAST_SPD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCEL_FRAMES - 1);

    typedef enum logic [1:0] {IDLE, SLOW, FAST} state_t;
    typedef enum logic [1:0] {REQ_NONE, REQ_UP, REQ_DN} req_t;

    logic             up_p0, up_p1;
    logic             dn_p0, dn_p1;
    logic             tick;
    req_t             req;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             dir_dn, dir_dn_nxt;
    logic [11:0]      y, y_nxt;
    logic [1:0]       com, com_nxt;
    logic [11:0]      spd;

    // Saturating moves: computed in a wider signed space so neither end wraps.
    function automatic logic [11:0] sat_up(input logic [11:0] pos, input logic [11:0] step);
        logic signed [13:0] diff;
        diff = $signed({2'b00, pos}) - $signed({2'b00, step});
        if (diff < $signed({2'b00, Y_MIN}))
            return Y_MIN;
        return diff[11:0];
    endfunction

    function automatic logic [11:0] sat_dn(input logic [11:0] pos, input logic [11:0] step);
        logic signed [13:0] sum;
        sum = $signed({2'b00, pos}) + $signed({2'b00, step});
        if (sum > $signed({2'b00, Y_MAX}))
            return Y_MAX;
        return sum[11:0];
    endfunction

    // Stage p0/p1: two-flop button synchronizers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            up_p0 <= 1'b0;
            up_p1 <= 1'b0;
            dn_p0 <= 1'b0;
            dn_p1 <= 1'b0;
        end else begin
            up_p0 <= i_btn_up;
            up_p1 <= up_p0;
            dn_p0 <= i_btn_dn;
            dn_p1 <= dn_p0;
        end
    end

    assign tick = i_ani_stb & i_animate & i_enable;
    assign req  = (up_p1 & ~dn_p1) ? REQ_UP :
                  (dn_p1 & ~up_p1) ? REQ_DN : REQ_NONE;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state  <= IDLE;
            cnt    <= '0;
            dir_dn <= 1'b0;
            y      <= Y_INIT;
            com    <= 2'b00;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            dir_dn <= dir_dn_nxt;
            y      <= y_nxt;
            com    <= com_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        dir_dn_nxt = dir_dn;
        y_nxt      = y;
        com_nxt    = com;
        spd        = SPD_SLOW;

        if (i_mode == 2'd0) begin
            // Not playing: hold the paddle parked at the centre every clock.
            state_nxt  = IDLE;
            cnt_nxt    = '0;
            dir_dn_nxt = 1'b0;
            y_nxt      = Y_INIT;
            com_nxt    = 2'b00;
        end else if (tick) begin
            if (req == REQ_NONE) begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                com_nxt   = 2'b00;
            end else begin
                dir_dn_nxt = (req == REQ_DN);
                // A fresh press or a reversal always restarts the slow phase.
                if (state == IDLE || dir_dn_nxt != dir_dn) begin
                    state_nxt = SLOW;
                    cnt_nxt   = '0;
                    spd       = SPD_SLOW;
                end else if (state == SLOW) begin
                    if (cnt == CNT_LAST) begin
                        state_nxt = FAST;
                        spd       = SPD_FAST;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                        spd     = SPD_SLOW;
                    end
                end else begin
                    state_nxt = FAST;
                    spd       = SPD_FAST;
                end
                y_nxt   = dir_dn_nxt ? sat_dn(y, spd) : sat_up(y, spd);
                com_nxt = {(y_nxt > y), (y_nxt < y)};
            end
        end
    end

    assign o_x1   = X_LEFT;
    assign o_x2   = X_RIGHT;
    assign o_y1   = y - HALF_H;
    assign o_y2   = y + HALF_H;
    assign o_com  = com;
    assign o_fast = (state == FAST);

endmodule

// File: tb/tb_paddle_ctrl.sv
// Scoreboard bench for paddle_ctrl: stimulus queues hand-computed paddle
// snapshots, a monitor compares them against the outputs on the falling edge.
module tb_paddle_ctrl;

    typedef struct packed {
        logic [11:0] x1;
        logic [11:0] x2;
        logic [11:0] y1;
        logic [11:0] y2;
        logic [1:0]  com;
        logic        fast;
    } snap_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ani_stb;
    logic        animate;
    logic        enable;
    logic [1:0]  mode;
    logic        btn_up;
    logic        btn_dn;
    logic [11:0] x1, x2, y1, y2;
    logic [1:0]  com;
    logic        fast;

    snap_t exp_q[$];
    string name_q[$];
    snap_t e;
    snap_t got;
    string nm;
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    paddle_ctrl dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_ani_stb (ani_stb),
        .i_animate (animate),
        .i_enable  (enable),
        .i_mode    (mode),
        .i_btn_up  (btn_up),
        .i_btn_dn  (btn_dn),
        .o_x1      (x1),
        .o_x2      (x2),
        .o_y1      (y1),
        .o_y2      (y2),
        .o_com     (com),
        .o_fast    (fast)
    );

    // Monitor: consumes one expected snapshot per falling edge when available.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            got = '{x1: x1, x2: x2, y1: y1, y2: y2, com: com, fast: fast};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL %s: got x1=%0d x2=%0d y1=%0d y2=%0d com=%b fast=%b, want x1=%0d x2=%0d y1=%0d y2=%0d com=%b fast=%b",
                         nm, got.x1, got.x2, got.y1, got.y2, got.com, got.fast,
                         e.x1, e.x2, e.y1, e.y2, e.com, e.fast);
            end
        end
    end

    task automatic chk(input string n, input int ey1, input int ey2,
                       input logic [1:0] ecom, input logic efast);
        snap_t s;
        s.x1   = 12'd595;
        s.x2   = 12'd605;
        s.y1   = 12'(ey1);
        s.y2   = 12'(ey2);
        s.com  = ecom;
        s.fast = efast;
        exp_q.push_back(s);
        name_q.push_back(n);
    endtask

    task automatic tick();
        @(posedge clk);
        #1 ani_stb = 1'b1;
        @(posedge clk);
        #1 ani_stb = 1'b0;
    endtask

    task automatic press(input logic u, input logic d);
        btn_up = u;
        btn_dn = d;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; ani_stb = 1'b0; animate = 1'b1; enable = 1'b1;
        mode = 2'd1; btn_up = 1'b0; btn_dn = 1'b0;

        @(posedge clk); #1;
        chk("reset", 200, 280, 2'b00, 1'b0);
        @(posedge clk); #1 rst = 1'b0;

        // Acceleration: 16 slow frames then the first fast frame.
        press(1'b1, 1'b0);
        repeat (16) tick();
        chk("slow16", 168, 248, 2'b01, 1'b0);
        tick();
        chk("fast17", 162, 242, 2'b01, 1'b1);

        press(1'b0, 1'b1); tick();
        chk("reverse_dn", 164, 244, 2'b10, 1'b0);
        press(1'b1, 1'b0); tick();
        chk("reverse_up", 162, 242, 2'b01, 1'b0);

        // Clamp at top, then at bottom.
        repeat (60) tick();
        chk("top_clamp", 0, 80, 2'b00, 1'b1);
        tick();
        chk("top_hold", 0, 80, 2'b00, 1'b1);
        press(1'b0, 1'b1); tick();
        chk("leave_top", 2, 82, 2'b10, 1'b0);
        repeat (150) tick();
        chk("bot_clamp", 400, 480, 2'b00, 1'b1);
        tick();
        chk("bot_hold", 400, 480, 2'b00, 1'b1);

        @(posedge clk); #1 mode = 2'd0;
        @(posedge clk); #1;
        chk("mode0_bottom", 200, 280, 2'b00, 1'b0);
        @(posedge clk); #1 mode = 2'd1;

        press(1'b1, 1'b1);
        repeat (5) tick();
        chk("both_buttons", 200, 280, 2'b00, 1'b0);

        press(1'b1, 1'b0);
        animate = 1'b0; tick();
        chk("no_animate", 200, 280, 2'b00, 1'b0);
        animate = 1'b1; enable = 1'b0; tick();
        chk("no_enable", 200, 280, 2'b00, 1'b0);
        enable = 1'b1; tick();
        chk("tick_up", 198, 278, 2'b01, 1'b0);
        press(1'b0, 1'b0); tick();
        chk("release", 198, 278, 2'b00, 1'b0);

        // From 238: 16 slow frames to 206, then 9 fast frames to 152.
        press(1'b1, 1'b0);
        repeat (25) tick();
        chk("mid_fast", 112, 192, 2'b01, 1'b1);
        @(posedge clk); #1 mode = 2'd0;
        @(posedge clk); #1;
        chk("mode0_mid", 200, 280, 2'b00, 1'b0);
        @(posedge clk); #1 mode = 2'd1;
        tick();
        chk("after_mode0", 198, 278, 2'b01, 1'b0);

        repeat (16) tick();
        chk("fast_again", 162, 242, 2'b01, 1'b1);
        @(posedge clk); #3 rst = 1'b1;
        #1 chk("async_rst", 200, 280, 2'b00, 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        press(1'b1, 1'b0); tick();
        chk("post_rst", 198, 278, 2'b01, 1'b0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
